mux7seg_scan_driver: RTL and testbench

- Time-multiplexed N-digit 7-segment driver; successor to the per-digit combinational decoders.
- Latches a packed BCD/hex word and scans one digit per refresh slot.
- Drives a shared segment bus plus one anode enable per digit.
- Adds leading-zero blanking, per-digit blink and an anti-ghosting dead cycle. Sits between the timer/control datapath and the board display pins.

---
 rtl/mux7seg_scan_driver_pkg.sv | 41 ++++
 rtl/seg7_code_decode.sv | 37 +++
 rtl/mux7seg_scan_driver.sv | 147 ++++++++++++++
 tb/tb_mux7seg_scan_driver.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/mux7seg_scan_driver_pkg.sv
// Shared definitions for the multiplexed 7-segment scan driver: segment
// patterns in active-low form {a,b,c,d,e,f,g} and width helpers.
package mux7seg_scan_driver_pkg;

  localparam logic [6:0] SEG_0   = 7'b0000001;
  localparam logic [6:0] SEG_1   = 7'b1001111;
  localparam logic [6:0] SEG_2   = 7'b0010010;
  localparam logic [6:0] SEG_3   = 7'b0000110;
  localparam logic [6:0] SEG_4   = 7'b1001100;
  localparam logic [6:0] SEG_5   = 7'b0100100;
  localparam logic [6:0] SEG_6   = 7'b0100000;
  localparam logic [6:0] SEG_7   = 7'b0001111;
  localparam logic [6:0] SEG_8   = 7'b0000000;
  localparam logic [6:0] SEG_9   = 7'b0000100;
  localparam logic [6:0] SEG_A   = 7'b0001000;
  localparam logic [6:0] SEG_B   = 7'b1100000;
  localparam logic [6:0] SEG_C   = 7'b0110001;
  localparam logic [6:0] SEG_D   = 7'b1000010;
  localparam logic [6:0] SEG_E   = 7'b0110000;
  localparam logic [6:0] SEG_F   = 7'b0111000;
  localparam logic [6:0] SEG_OFF = 7'b1111111;

  // Ceiling log2; returns 0 for values <= 1.
  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

  // Bits needed to count 0..count-1, never narrower than one bit.
  function automatic int width_of(input int count);
    return (clog2(count) < 1) ? 1 : clog2(count);
  endfunction

endpackage

// File: rtl/seg7_code_decode.sv
// Combinational 4-bit code to 7-segment pattern (active-low form).
// Codes 10-15 are letters when HEX_EN is set, otherwise blank.
module seg7_code_decode
  import mux7seg_scan_driver_pkg::*;
#(
  parameter int HEX_EN = 0
) (
  input  logic [3:0] code_i,
  output logic [6:0] seg_o
);

  // Pattern lookup; letters collapse to blank in decimal-only builds.
  always_comb begin
    // NOTE: assign a default before the case so every path drives seg_o and no latch is inferred.
    seg_o = SEG_OFF;
    case (code_i)
      4'h0:    seg_o = SEG_0;
      4'h1:    seg_o = SEG_1;
      4'h2:    seg_o = SEG_2;
      4'h3:    seg_o = SEG_3;
      4'h4:    seg_o = SEG_4;
      4'h5:    seg_o = SEG_5;
      4'h6:    seg_o = SEG_6;
      4'h7:    seg_o = SEG_7;
      4'h8:    seg_o = SEG_8;
      4'h9:    seg_o = SEG_9;
      4'hA:    seg_o = (HEX_EN != 0) ? SEG_A : SEG_OFF;
      4'hB:    seg_o = (HEX_EN != 0) ? SEG_B : SEG_OFF;
      4'hC:    seg_o = (HEX_EN != 0) ? SEG_C : SEG_OFF;
      4'hD:    seg_o = (HEX_EN != 0) ? SEG_D : SEG_OFF;
      4'hE:    seg_o = (HEX_EN != 0) ? SEG_E : SEG_OFF;
      4'hF:    seg_o = (HEX_EN != 0) ? SEG_F : SEG_OFF;
      default: seg_o = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/mux7seg_scan_driver.sv
// Time-multiplexed N-digit 7-segment driver. A prescaler divides clk into
// digit slots; each slot starts with one dark cycle to stop ghosting, then
// lights the selected digit. Supports leading-zero blanking and per-digit blink.
module mux7seg_scan_driver
  import mux7seg_scan_driver_pkg::*;
#(
  parameter int NUM_DIGITS     = 3,
  parameter int REFRESH_DIV    = 50000,
  parameter int BLINK_FRAMES   = 64,
  parameter int HEX_EN         = 0,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1,
  localparam int SCAN_W        = width_of(NUM_DIGITS)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic                    load,
  input  logic                    blank_lz,
  input  logic                    blink_en,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  output logic [6:0]              segs,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [SCAN_W-1:0]       scan_idx,
  output logic                    frame_tick
);

  localparam int PRE_W = width_of(REFRESH_DIV);
  localparam int FRM_W = width_of(BLINK_FRAMES);

  localparam logic [6:0]            SEGS_DARK = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic [NUM_DIGITS-1:0] AN_DARK   = (AN_ACTIVE_LOW != 0) ? '1 : '0;

  logic [PRE_W-1:0]        prescaler_q, prescaler_d;
  logic [SCAN_W-1:0]       scan_idx_q, scan_idx_d;
  logic [FRM_W-1:0]        frame_cnt_q, frame_cnt_d;
  logic                    blink_phase_q, blink_phase_d;
  logic                    frame_tick_q, frame_tick_d;
  logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
  logic [6:0]              segs_q, segs_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;

  logic                    terminal;
  logic                    frame_wrap;
  logic                    dead;
  logic [NUM_DIGITS-1:0]   digit_blank;
  logic [NUM_DIGITS-1:0]   an_onehot;
  logic [3:0]              sel_code;
  logic                    sel_blank;
  logic [6:0]              sel_pattern;
  logic [6:0]              seg_raw;
  logic [NUM_DIGITS-1:0]   an_raw;

  assign terminal   = (prescaler_q == PRE_W'(REFRESH_DIV - 1));
  assign frame_wrap = terminal && (scan_idx_q == SCAN_W'(NUM_DIGITS - 1));
  assign dead       = (prescaler_q == '0);

  // Timing chain: prescaler, scan index, frame counter, blink phase, shadow.
  always_comb begin
    prescaler_d   = terminal ? '0 : prescaler_q + PRE_W'(1);
    scan_idx_d    = scan_idx_q;
    frame_cnt_d   = frame_cnt_q;
    blink_phase_d = blink_phase_q;
    frame_tick_d  = frame_wrap;
    shadow_d      = load ? digits_in : shadow_q;
    if (terminal) begin
      scan_idx_d = frame_wrap ? '0 : scan_idx_q + SCAN_W'(1);
    end
    if (frame_wrap) begin
      if (frame_cnt_q == FRM_W'(BLINK_FRAMES - 1)) begin
        frame_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        frame_cnt_d = frame_cnt_q + FRM_W'(1);
      end
    end
  end

  // Per-digit blanking, then select the digit in the current slot.
  always_comb begin
    logic zero_above;
    zero_above  = 1'b1;
    digit_blank = '0;
    an_onehot   = '0;
    sel_code    = 4'h0;
    sel_blank   = 1'b0;
    // Walk from the most significant digit down, tracking "all zero so far".
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_above     = zero_above && (shadow_q[4*i +: 4] == 4'h0);
      digit_blank[i] = (blank_lz && zero_above && (i != 0)) ||
                       (blink_en && blink_phase_q && blink_mask[i]);
    end
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (scan_idx_q == SCAN_W'(i)) begin
        sel_code     = shadow_q[4*i +: 4];
        sel_blank    = digit_blank[i];
        an_onehot[i] = 1'b1;
      end
    end
  end

  seg7_code_decode #(
    .HEX_EN (HEX_EN)
  ) u_decode (
    .code_i (sel_code),
    .seg_o  (sel_pattern)
  );

  // Output register inputs: dark on the first cycle of a slot, polarity last.
  always_comb begin
    seg_raw = (dead || sel_blank) ? SEG_OFF : sel_pattern;
    an_raw  = dead ? '0 : an_onehot;
    segs_d  = (SEG_ACTIVE_LOW != 0) ? seg_raw : ~seg_raw;
    an_d    = (AN_ACTIVE_LOW != 0) ? ~an_raw : an_raw;
  end

  // All state, with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      prescaler_q   <= '0;
      scan_idx_q    <= '0;
      frame_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      frame_tick_q  <= 1'b0;
      // NOTE: the shadow is reset on purpose so a freshly reset display shows zeros, not stale digits.
      shadow_q      <= '0;
      segs_q        <= SEGS_DARK;
      an_q          <= AN_DARK;
    end else begin
      prescaler_q   <= prescaler_d;
      scan_idx_q    <= scan_idx_d;
      frame_cnt_q   <= frame_cnt_d;
      blink_phase_q <= blink_phase_d;
      frame_tick_q  <= frame_tick_d;
      shadow_q      <= shadow_d;
      segs_q        <= segs_d;
      an_q          <= an_d;
    end
  end

  assign segs       = segs_q;
  assign an         = an_q;
  assign scan_idx   = scan_idx_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_mux7seg_scan_driver.sv
// Bench for mux7seg_scan_driver: two instances (decimal-only and hex) share
// stimulus; a cycle-count reference model predicts every output each cycle.
module tb_mux7seg_scan_driver;

  localparam int N  = 3;
  localparam int R  = 4;
  localparam int BF = 2;

  logic        clk;
  logic        rst_n;
  logic [11:0] digits_in;
  logic        load;
  logic        blank_lz;
  logic        blink_en;
  logic [2:0]  blink_mask;

  logic [6:0]  segs, segs_h;
  logic [2:0]  an, an_h;
  logic [1:0]  scan_idx, scan_idx_h;
  logic        frame_tick, frame_tick_h;

  int n_checks = 0;
  int n_errors = 0;

  mux7seg_scan_driver #(
    .NUM_DIGITS(N), .REFRESH_DIV(R), .BLINK_FRAMES(BF),
    .HEX_EN(0), .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .digits_in(digits_in), .load(load),
    .blank_lz(blank_lz), .blink_en(blink_en), .blink_mask(blink_mask),
    .segs(segs), .an(an), .scan_idx(scan_idx), .frame_tick(frame_tick)
  );

  mux7seg_scan_driver #(
    .NUM_DIGITS(N), .REFRESH_DIV(R), .BLINK_FRAMES(BF),
    .HEX_EN(1), .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)
  ) dut_hex (
    .clk(clk), .rst_n(rst_n), .digits_in(digits_in), .load(load),
    .blank_lz(blank_lz), .blink_en(blink_en), .blink_mask(blink_mask),
    .segs(segs_h), .an(an_h), .scan_idx(scan_idx_h), .frame_tick(frame_tick_h)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: everything derives from cycles elapsed since reset.
  logic [6:0]  dec_tab [16];
  int          cyc;
  logic [11:0] m_shadow;
  logic [6:0]  exp_segs, exp_segs_hex;
  logic [2:0]  exp_an;
  logic [1:0]  exp_idx;
  logic        exp_tick;
  bit          model_valid = 0;

  initial begin
    dec_tab[0]  = 7'b0000001; dec_tab[1]  = 7'b1001111;
    dec_tab[2]  = 7'b0010010; dec_tab[3]  = 7'b0000110;
    dec_tab[4]  = 7'b1001100; dec_tab[5]  = 7'b0100100;
    dec_tab[6]  = 7'b0100000; dec_tab[7]  = 7'b0001111;
    dec_tab[8]  = 7'b0000000; dec_tab[9]  = 7'b0000100;
    dec_tab[10] = 7'b0001000; dec_tab[11] = 7'b1100000;
    dec_tab[12] = 7'b0110001; dec_tab[13] = 7'b1000010;
    dec_tab[14] = 7'b0110000; dec_tab[15] = 7'b0111000;
  end

  always @(posedge clk) begin
    int         pos, slot, frames;
    bit         phase, blank;
    logic [3:0] code;
    if (!rst_n) begin
      cyc          = 0;
      m_shadow     = 12'h000;
      exp_segs     = 7'h7F;
      exp_segs_hex = 7'h7F;
      exp_an       = 3'b111;
      exp_idx      = 2'd0;
      exp_tick     = 1'b0;
    end else begin
      // Outputs of the new cycle come from the state of the cycle just ended.
      pos    = cyc % R;
      slot   = (cyc / R) % N;
      frames = cyc / (R * N);
      phase  = ((frames / BF) % 2) == 1;
      code   = m_shadow[4*slot +: 4];
      blank  = (blank_lz && slot > 0 && (m_shadow >> (4 * slot)) == 12'h000) ||
               (blink_en && phase && blink_mask[slot]);
      if (pos == 0) begin
        exp_an       = 3'b111;
        exp_segs     = 7'h7F;
        exp_segs_hex = 7'h7F;
      end else begin
        exp_an       = ~(3'b001 << slot);
        exp_segs     = (blank || code > 4'd9) ? 7'h7F : dec_tab[code];
        exp_segs_hex = blank ? 7'h7F : dec_tab[code];
      end
      if (load) m_shadow = digits_in;
      cyc      = cyc + 1;
      exp_idx  = 2'((cyc / R) % N);
      exp_tick = (cyc % (R * N)) == 0;
    end
    model_valid = 1;
  end

  always @(negedge clk) begin
    if (model_valid) begin
      check("segs", 32'(segs), 32'(exp_segs));
      check("an", 32'(an), 32'(exp_an));
      check("scan_idx", 32'(scan_idx), 32'(exp_idx));
      check("frame_tick", 32'(frame_tick), 32'(exp_tick));
      check("segs_hex", 32'(segs_h), 32'(exp_segs_hex));
      check("an_hex", 32'(an_h), 32'(exp_an));
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic load_word(input logic [11:0] w);
    digits_in = w;
    load      = 1'b1;
    step(1);
    load      = 1'b0;
  endtask

  // Bounded wait for a given anode pattern, then check the decimal segments.
  task automatic expect_digit(input string tag, input logic [2:0] an_want, input logic [6:0] seg_want);
    bit found;
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (an == an_want) found = 1;
    end
    if (found) check(tag, 32'(segs), 32'(seg_want));
    else       check({tag, "_timeout"}, 32'(an), 32'(an_want));
    step(1);
  endtask

  initial begin
    bit found;
    logic [11:0] w;
    rst_n      = 1'b0;
    load       = 1'b0;
    digits_in  = 12'h000;
    blank_lz   = 1'b0;
    blink_en   = 1'b0;
    blink_mask = 3'b000;
    step(3);
    // Load during reset must be ignored.
    digits_in = 12'h999;
    load      = 1'b1;
    step(1);
    load      = 1'b0;
    rst_n     = 1'b1;
    expect_digit("first_lit_d0", 3'b110, 7'b0000001);
    step(12);

    load_word(12'h372);
    step(2);
    expect_digit("d0_372", 3'b110, 7'b0010010);
    expect_digit("d1_372", 3'b101, 7'b0001111);
    expect_digit("d2_372", 3'b011, 7'b0000110);
    step(12);

    blank_lz = 1'b1;
    load_word(12'h005);
    step(2);
    expect_digit("lz_d2", 3'b011, 7'b1111111);
    expect_digit("lz_d0", 3'b110, 7'b0100100);
    load_word(12'h000);
    step(2);
    expect_digit("lz_all0_d0", 3'b110, 7'b0000001);
    step(12);

    blank_lz   = 1'b0;
    blink_en   = 1'b1;
    blink_mask = 3'b010;
    load_word(12'h123);
    step(72);

    blink_en = 1'b0;
    blank_lz = 1'b1;
    load_word(12'h0B0);
    step(24);
    load_word(12'hB00);
    step(24);

    // Reset while slot 2 is active.
    blank_lz = 1'b0;
    load_word(12'h456);
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (scan_idx == 2'd2) found = 1;
    end
    if (!found) check("wait_slot2_timeout", 32'(scan_idx), 32'd2);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    expect_digit("post_rst_d1", 3'b101, 7'b0000001);
    step(12);

    // Randomized traffic, biased toward zero digits to exercise blanking.
    for (int c = 0; c < 400; c++) begin
      rst_n = ($urandom_range(0, 99) != 0);
      load  = ($urandom_range(0, 3) == 0);
      w = 12'h000;
      for (int d = 0; d < N; d++) begin
        if ($urandom_range(0, 2) != 0) w[4*d +: 4] = 4'($urandom_range(0, 15));
      end
      digits_in = w;
      if ($urandom_range(0, 7) == 0) blank_lz   = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) blink_en   = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) blink_mask = 3'($urandom_range(0, 7));
      step(1);
    end
    rst_n = 1'b1;
    load  = 1'b0;
    step(4);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
